// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: load N words, sort with one shared compare-exchange unit, drain ascending.
// Optional SORT_SWAP_COUNT_EN adds a swap_count output reporting swaps in the last batch.
module bitonic_sort_seq #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int LOG2N = $clog2(N)
`ifdef SORT_SWAP_COUNT_EN
  , localparam int C = (N / 2) * LOG2N * (LOG2N + 1) / 2,
  localparam int CW = (C > 32) ? 32 : C
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
`ifdef SORT_SWAP_COUNT_EN
  , output logic [CW-1:0] swap_count
`endif
);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam logic [LOG2N-1:0] IDX_MAX  = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] PAIR_MAX = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] STG_MAX  = LOG2N'(LOG2N - 1);

  state_t           state, state_nx;
  logic [W-1:0]     mem [N];
  logic [LOG2N-1:0] wr_idx, rd_idx;
  logic [LOG2N-1:0] stg, sub, pr;
  logic [LOG2N-1:0] jm, ia, la;
  logic [LOG2N:0]   kmask;
  logic [W-1:0]     wa, wb;
  logic             desc, do_swap, last_cmp;

  // stg is s-1, sub is log2(j), pr is p; i = (p/j)*2j + p%j, l = i + j.
  always_comb begin
    jm       = LOG2N'(1) << sub;
    ia       = (((pr >> sub) << sub) << 1) | (pr & (jm - 1'b1));
    la       = ia + jm;
    kmask    = (LOG2N + 1)'(2) << stg;
    desc     = |({1'b0, ia} & kmask);
    wa       = mem[ia];
    wb       = mem[la];
    do_swap  = (state == SORT) && (desc ? (wa < wb) : (wa > wb));
    last_cmp = (stg == STG_MAX) && (sub == '0) && (pr == PAIR_MAX);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && (wr_idx == IDX_MAX)) state_nx = SORT;
      end
      SORT: begin
        if (last_cmp) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        out_last  = (rd_idx == IDX_MAX);
        if (out_ready && (rd_idx == IDX_MAX)) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      stg    <= '0;
      sub    <= '0;
      pr     <= '0;
      mem    <= '{default: '0};
    end else begin
      state <= state_nx;
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            mem[wr_idx] <= in_data;
            wr_idx      <= wr_idx + 1'b1;
            if (wr_idx == IDX_MAX) begin
              stg <= '0;
              sub <= '0;
              pr  <= '0;
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            mem[ia] <= wb;
            mem[la] <= wa;
          end
          // On substage wrap, the next stage starts with j = k/2, i.e. sub = new stg.
          if (pr == PAIR_MAX) begin
            pr <= '0;
            if (sub == '0) begin
              stg <= stg + 1'b1;
              sub <= stg + 1'b1;
            end else begin
              sub <= sub - 1'b1;
            end
          end else begin
            pr <= pr + 1'b1;
          end
          if (last_cmp) rd_idx <= '0;
        end
        DRAIN: begin
          if (out_ready) rd_idx <= rd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_SWAP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_count <= '0;
    end else if ((state == LOAD) && (state_nx == SORT)) begin
      swap_count <= '0;
    end else if (do_swap) begin
      swap_count <= swap_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Directed bench for bitonic_sort_seq: N=8 instance for the main scenarios, N=2 instance for the minimal case.
module tb_bitonic_sort_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, out_data;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
  logic [7:0] in_data2, out_data2;
`ifdef SORT_SWAP_COUNT_EN
  logic [23:0] swap_count;
  logic        swap_count2;
`endif

  bitonic_sort_seq #(.N(8), .W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
`ifdef SORT_SWAP_COUNT_EN
    , .swap_count(swap_count)
`endif
  );

  bitonic_sort_seq #(.N(2), .W(8)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .busy(busy2)
`ifdef SORT_SWAP_COUNT_EN
    , .swap_count(swap_count2)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  vec   [8];
  logic [7:0]  exp_v [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes vec[0..7]; leaves in_valid high afterwards when hold is set.
  task automatic load8(input bit hold);
    int guard;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = vec[n];
      guard    = 0;
      while (!in_ready && guard < 200) begin
        tick();
        guard++;
      end
      check("load_ready", in_ready, 1);
      tick();
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Called one cycle after the last input handshake (cycle 1); ends in cycle 25.
  task automatic sort_timing();
    check("sort_busy", busy, 1);
    for (int c = 1; c <= 24; c++) begin
      check("sort_out_valid", out_valid, 0);
      check("sort_in_ready", in_ready, 0);
      tick();
    end
    check("first_out_valid_c25", out_valid, 1);
  endtask

  task automatic drain8(input bit bp);
    int         n = 0;
    int         guard = 0;
    bit         hs;
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    while (n < 8 && guard < 400) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check("drain_valid", out_valid, 1);
      if (stalled) check("drain_hold", out_data, held);
      check("drain_data", out_data, exp_v[n]);
      check("drain_last", out_last, (n == 7) ? 1 : 0);
      check("drain_in_ready", in_ready, 0);
      hs      = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held    = out_data;
      tick();
      guard++;
      if (hs) n++;
    end
    check("drain_count", n, 8);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready2", in_ready2, 1);
`ifdef SORT_SWAP_COUNT_EN
    check("rst_swap_count", swap_count, 0);
`endif
    reset = 1'b0;
    tick();

    // Reverse order
    vec   = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    exp_v = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load8(1'b0);
    sort_timing();
    drain8(1'b0);

    // Duplicates and extremes under random backpressure
    vec   = '{8'd200, 8'd3, 8'd3, 8'd255, 8'd0, 8'd17, 8'd3, 8'd128};
    exp_v = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd17, 8'd128, 8'd200, 8'd255};
    load8(1'b0);
    sort_timing();
    drain8(1'b1);

    // All equal: strict compare never swaps
    vec   = '{default: 8'd42};
    exp_v = '{default: 8'd42};
    load8(1'b0);
    sort_timing();
`ifdef SORT_SWAP_COUNT_EN
    check("swap_count_equal", swap_count, 0);
`endif
    drain8(1'b0);

    // Reset in SORT cycle 10 discards the batch
    vec = '{8'd5, 8'd9, 8'd1, 8'd250, 8'd7, 8'd7, 8'd33, 8'd2};
    load8(1'b0);
    repeat (9) tick();
    check("mid_sort_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_last", out_last, 0);
    vec   = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    load8(1'b0);
    sort_timing();
    drain8(1'b0);

    // Back-to-back batches with in_valid held high
    vec   = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    exp_v = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9};
    load8(1'b1);
    sort_timing();
    drain8(1'b0);
    vec   = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    exp_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load8(1'b0);
    sort_timing();
    drain8(1'b0);

    // N=2: one compare, out_valid in cycle 2
    check("n2_in_ready", in_ready2, 1);
    in_valid2 = 1'b1;
    in_data2  = 8'd9;
    tick();
    in_data2  = 8'd4;
    tick();
    in_valid2 = 1'b0;
    check("n2_c1_valid", out_valid2, 0);
    check("n2_c1_busy", busy2, 1);
    tick();
    out_ready2 = 1'b1;
    check("n2_c2_valid", out_valid2, 1);
    check("n2_data0", out_data2, 4);
    check("n2_last0", out_last2, 0);
`ifdef SORT_SWAP_COUNT_EN
    check("n2_swap_count", swap_count2, 1);
`endif
    tick();
    check("n2_data1", out_data2, 9);
    check("n2_last1", out_last2, 1);
    tick();
    out_ready2 = 1'b0;
    check("n2_post_in_ready", in_ready2, 1);
    check("n2_post_valid", out_valid2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
